key_event_gen: RTL and testbench

//  - Consumes the clean, debounced button level `key` and classifies each press into events.
//  - Events are single-clk pulses: short press (on release), long press, and optional auto-repeat.
//  - These pulses feed the watch mode/set-time control logic.
//  - Operates entirely in the clk domain; input is already synchronous and glitch-free.

---
 rtl/key_pkg.sv | 8 +
 rtl/ms_tick_gen.sv | 16 +
 rtl/key_event_gen.sv | 112 +++++++++++
 tb/tb_key_event_gen.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared state encoding for the key event FSM.
package key_pkg;
    typedef logic [1:0] state_t;
    localparam state_t WAIT_REL = 2'd0;
    localparam state_t IDLE     = 2'd1;
    localparam state_t PRESS    = 2'd2;
    localparam state_t LONG     = 2'd3;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running divider, one-clk tick every CLK_DIV clocks.
module ms_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    logic [CW-1:0] cnt_q;
    assign tick = cnt_q == LAST;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= tick ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: classifies debounced key presses into short/long/repeat pulses.
// Auto-repeat is built only when KEY_AUTO_REPEAT_EN is defined.
module key_event_gen
    import key_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press_o,
    output logic long_o,
    output logic rpt_o,
    output logic held_o
);
    localparam int HW = $clog2(LONG_MS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_MS);
    logic tick, key_q, key_qq, rise, fall;
    logic press_q, press_d, long_q, long_d, held_q, held_d;
    logic [HW-1:0] hold_q, hold_d;
    state_t state_q, state_d;
`ifdef KEY_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_MS + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_MS - 1);
    localparam logic [RW-1:0] RPT_MAX  = RW'(REPEAT_MS);
    logic rpt_q, rpt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
`endif

    ms_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    assign rise = key_q & ~key_qq;
    assign fall = ~key_q & key_qq;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        press_d = 1'b0;
        long_d  = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        rpt_d   = 1'b0;
        rcnt_d  = rcnt_q;
`endif
        case (state_q)
            // Raw key is also checked so the reset value of key_q cannot fake a release.
            WAIT_REL: if (!key && !key_q) state_d = IDLE;
            IDLE: if (rise) begin
                state_d = PRESS;
                hold_d  = '0;
            end
            PRESS: if (fall) begin
                press_d = 1'b1;
                state_d = IDLE;
            end else if (tick && hold_q == HOLD_LAST) begin
                long_d  = 1'b1;
                state_d = LONG;
`ifdef KEY_AUTO_REPEAT_EN
                rcnt_d  = '0;
`endif
            end else if (tick && hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
            LONG: if (fall) state_d = IDLE;
`ifdef KEY_AUTO_REPEAT_EN
            else if (tick && rcnt_q == RPT_LAST) begin
                rpt_d  = 1'b1;
                rcnt_d = '0;
            end else if (tick && rcnt_q != RPT_MAX) rcnt_d = rcnt_q + 1'b1;
`endif
            default: state_d = WAIT_REL;
        endcase
        held_d = state_d == PRESS || state_d == LONG;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            key_q   <= 1'b0;
            key_qq  <= 1'b0;
            state_q <= WAIT_REL;
            hold_q  <= '0;
            press_q <= 1'b0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            key_q   <= key;
            key_qq  <= key_q;
            state_q <= state_d;
            hold_q  <= hold_d;
            press_q <= press_d;
            long_q  <= long_d;
            held_q  <= held_d;
        end

`ifdef KEY_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rcnt_q <= '0;
            rpt_q  <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            rpt_q  <= rpt_d;
        end
    assign rpt_o = rpt_q;
`else
    assign rpt_o = 1'b0;
`endif

    assign press_o = press_q;
    assign long_o  = long_q;
    assign held_o  = held_q;
endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: scoreboard bench; expected pulses are queued with their cycle, a monitor pops and compares.
module tb_key_event_gen;
    localparam int D    = 50;
    localparam int LONG = 10;
    localparam int RPT  = 4;

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } ev_t;

    logic clk = 1'b0, rst = 1'b0, key = 1'b0;
    logic press_o, long_o, rpt_o, held_o;
    int cyc = 0, vecs = 0, errs = 0;
    ev_t q[$];

    key_event_gen #(.CLK_DIV(D), .LONG_MS(LONG), .REPEAT_MS(RPT)) dut (
        .clk(clk), .rst(rst), .key(key),
        .press_o(press_o), .long_o(long_o), .rpt_o(rpt_o), .held_o(held_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    function automatic void exp_ev(logic [2:0] c, int t);
        ev_t e;
        e.code = c;
        e.cyc  = t;
        q.push_back(e);
    endfunction

    task automatic chk(string nm, logic got, logic exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b, expected %b at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ticks are seen at edges that are multiples of D; PRESS is entered at edge a+2.
    function automatic int first_tick(int a);
        return ((a + 3 + D - 1) / D) * D;
    endfunction

    function automatic int boundary_len(int a);
        return first_tick(a) + D * (LONG - 1) - 2 - a;
    endfunction

    task automatic run(int len);
        int a, t0, f;
        a  = cyc;
        t0 = first_tick(a);
        f  = a + len + 2;
        if (f <= t0 + D * (LONG - 1)) exp_ev(3'b100, f);
        else begin
            exp_ev(3'b010, t0 + D * (LONG - 1));
`ifdef KEY_AUTO_REPEAT_EN
            for (int k = LONG - 1 + RPT; t0 + D * k < f; k += RPT) exp_ev(3'b001, t0 + D * k);
`endif
        end
        key = 1'b1;
        if (len > 5) begin
            step(5);
            chk("held_mid", held_o, 1'b1);
            step(len - 5);
        end else step(len);
        key = 1'b0;
        step(20);
        chk("held_rel", held_o, 1'b0);
    endtask

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst && (press_o || long_o || rpt_o)) begin
                vecs++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_pulse: got {press,long,rpt}=%b at cycle %0d, expected none", {press_o, long_o, rpt_o}, cyc);
                end else begin
                    e = q.pop_front();
                    if ({press_o, long_o, rpt_o} !== e.code || cyc != e.cyc) begin
                        errs++;
                        $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d", {press_o, long_o, rpt_o}, cyc, e.code, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, expected end before 1 ms");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_press", press_o, 1'b0);
        chk("rst_long", long_o, 1'b0);
        chk("rst_rpt", rpt_o, 1'b0);
        chk("rst_held", held_o, 1'b0);
        #21 rst = 1'b1;
        step(10);
        run(5 * D);
        run(25 * D);
        run(boundary_len(cyc));
        run(boundary_len(cyc) + 1);
        run(1);
        key = 1'b1;
        step(5 * D);
        rst = 1'b0;
        #1;
        chk("mid_rst_held", held_o, 1'b0);
        chk("mid_rst_press", press_o, 1'b0);
        step(3);
        #2 rst = 1'b1;
        step(20 * D);
        chk("held_after_rst", held_o, 1'b0);
        key = 1'b0;
        step(20);
        run(3 * D);
        step(5);
        vecs++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL missing_pulses: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
